fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 20 ++
 rtl/fifo_uart_tx_if.sv | 22 ++
 rtl/uart_baud_cnt.sv | 28 ++
 rtl/fifo_uart_tx.sv | 114 +++++++++++
 tb/tb_fifo_uart_tx.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared FSM state type and default sizing for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state between DATA and STOP.
package fifo_uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_W_DEF       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        ST_PARITY = 3'd5,
`endif
        ST_STOP   = 3'd6
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO-side and serial-side signals of the UART transmitter; master is the FIFO/system side.
// The transmitter (slave) owns fifo_rd_en, tx and busy.
interface fifo_uart_tx_if import fifo_uart_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
);
    logic              fifo_empty;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_rd_en;
    logic              tx;
    logic              busy;

    modport master (
        output fifo_empty, fifo_wr_en, fifo_data,
        input  fifo_rd_en, tx, busy
    );

    modport slave (
        input  fifo_empty, fifo_wr_en, fifo_data,
        output fifo_rd_en, tx, busy
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Per-bit timer: bit_done pulses on the last of every CLKS_PER_BIT enabled cycles.
// No backpressure; clear wins over enable and restarts the bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);
    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter pulling bytes from a registered-output FIFO; 2-cycle fetch/load gap per frame.
// Reads only when the FIFO is non-empty and not being written; FIFO_UART_TX_PARITY_EN adds even parity.
module fifo_uart_tx import fifo_uart_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_W       = DATA_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_uart_tx_if.slave  bus
);
    localparam int            IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [IW-1:0]     bit_idx, bit_idx_nxt;
    logic              tx_q, tx_d;
    logic              bit_done, in_frame, baud_clear, can_fetch;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q;
`endif

    // A read issued alongside a write is ignored by the FIFO, so never start one then.
    assign can_fetch  = !bus.fifo_empty && !bus.fifo_wr_en;
    assign in_frame   = !(state inside {ST_IDLE, ST_FETCH, ST_LOAD});
    assign baud_clear = !in_frame;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .enable   (in_frame),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (can_fetch) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = bus.fifo_wr_en ? ST_IDLE : ST_LOAD;
            ST_LOAD:   state_nxt = ST_START;
            ST_START:  if (bit_done) state_nxt = ST_DATA;
            ST_DATA: begin
                if (bit_done && (bit_idx == LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: if (bit_done) state_nxt = ST_STOP;
`endif
            ST_STOP:   if (bit_done) state_nxt = can_fetch ? ST_FETCH : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        if (state == ST_LOAD) begin
            shreg_nxt   = bus.fifo_data;
            bit_idx_nxt = '0;
        end else if ((state == ST_DATA) && bit_done) begin
            shreg_nxt   = shreg >> 1;
            bit_idx_nxt = (bit_idx == LAST_BIT) ? '0 : bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
            if (state == ST_LOAD) par_q <= ^bus.fifo_data;
`endif
        end
    end

    // tx is registered from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        tx_d           = 1'b1;
        bus.fifo_rd_en = (state == ST_FETCH);
        bus.busy       = (state != ST_IDLE);
        case (state_nxt)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_q <= 1'b1;
        else        tx_q <= tx_d;
    end

    assign bus.tx = tx_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, DATA_W=8 with a small registered-read FIFO model.
// Frame constants carry the parity bit when FIFO_UART_TX_PARITY_EN is defined.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    localparam int DW  = 8;

    // Frames are listed line-order from bit 0: start, data LSB first, [parity], stop.
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int          NB   = DW + 3;
    localparam logic [15:0] F_A5 = {5'd0, 1'b1, 1'b0, 8'hA5, 1'b0};
    localparam logic [15:0] F_07 = {5'd0, 1'b1, 1'b1, 8'h07, 1'b0};
    localparam logic [15:0] F_01 = {5'd0, 1'b1, 1'b1, 8'h01, 1'b0};
    localparam logic [15:0] F_80 = {5'd0, 1'b1, 1'b1, 8'h80, 1'b0};
    localparam logic [15:0] F_3C = {5'd0, 1'b1, 1'b0, 8'h3C, 1'b0};
    localparam logic [15:0] F_5A = {5'd0, 1'b1, 1'b0, 8'h5A, 1'b0};
`else
    localparam int          NB   = DW + 2;
    localparam logic [15:0] F_A5 = 16'b000000_1_10100101_0;
    localparam logic [15:0] F_07 = {6'd0, 1'b1, 8'h07, 1'b0};
    localparam logic [15:0] F_01 = {6'd0, 1'b1, 8'h01, 1'b0};
    localparam logic [15:0] F_80 = {6'd0, 1'b1, 8'h80, 1'b0};
    localparam logic [15:0] F_3C = {6'd0, 1'b1, 8'h3C, 1'b0};
    localparam logic [15:0] F_5A = {6'd0, 1'b1, 8'h5A, 1'b0};
`endif

    logic clk = 1'b0;
    logic rst_n;

    fifo_uart_tx_if #(.DATA_W(DW)) bus ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO model: read data updates in the FETCH cycle, ready for the LOAD capture edge.
    logic [7:0] mem [0:15];
    int wr_cnt = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;

    always @(negedge clk) begin
        if (bus.fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.fifo_rd_en && !bus.fifo_wr_en && (rd_ptr != wr_cnt)) begin
            bus.fifo_data  <= mem[rd_ptr[3:0]];
            rd_ptr         <= rd_ptr + 1;
            bus.fifo_empty <= ((rd_ptr + 1) == wr_cnt);
        end else begin
            bus.fifo_empty <= (rd_ptr == wr_cnt);
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_cnt[3:0]] = b;
        wr_cnt++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch(input string tag);
        int n = 0;
        while ((bus.fifo_rd_en !== 1'b1) && (n < 200)) begin
            cyc();
            n++;
        end
        check_eq(tag, 32'(bus.fifo_rd_en), 32'd1);
    endtask

    // Called in the FETCH cycle; returns in the last cycle of the stop bit.
    task automatic check_frame(input string tag, input logic [15:0] frm);
        logic [CPB-1:0] obs;
        int             bad_busy = 0;
        check_eq({tag, "_fetch_tx"}, 32'(bus.tx), 32'd1);
        cyc();
        check_eq({tag, "_load"}, 32'({bus.tx, bus.busy, bus.fifo_rd_en}), 32'b110);
        for (int k = 0; k < NB; k++) begin
            obs = '0;
            for (int j = 0; j < CPB; j++) begin
                cyc();
                obs[j] = bus.tx;
                if (bus.busy !== 1'b1) bad_busy++;
            end
            check_eq($sformatf("%s_bit%0d", tag, k), 32'(obs), 32'({CPB{frm[k]}}));
        end
        check_eq({tag, "_busy_low_cycles"}, 32'(bad_busy), 32'd0);
    endtask

    int r0;
    int bad;

    initial begin
        rst_n          = 1'b1;
        bus.fifo_wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("reset_outputs", 32'({bus.tx, bus.busy, bus.fifo_rd_en}), 32'b100);
        repeat (3) cyc();
        rst_n = 1'b1;

        // Empty FIFO for 100 cycles: line idle, never a read.
        r0  = rd_cnt;
        bad = 0;
        repeat (100) begin
            cyc();
            if ((bus.tx !== 1'b1) || (bus.busy !== 1'b0) || (bus.fifo_rd_en !== 1'b0)) bad++;
        end
        check_eq("idle_bad_cycles", 32'(bad), 32'd0);
        check_eq("idle_rd_pulses", 32'(rd_cnt - r0), 32'd0);

        // Single byte 0xA5.
        r0 = rd_cnt;
        push(8'hA5);
        wait_fetch("a5_fetch");
        check_frame("a5", F_A5);
        cyc();
        check_eq("a5_end_busy", 32'(bus.busy), 32'd0);
        check_eq("a5_rd_pulses", 32'(rd_cnt - r0), 32'd1);

        // 0x07: odd number of ones.
        push(8'h07);
        wait_fetch("b07_fetch");
        check_frame("b07", F_07);
        cyc();
        check_eq("b07_end_busy", 32'(bus.busy), 32'd0);

        // Back-to-back 0x01, 0x80: FETCH directly after the first stop bit.
        r0 = rd_cnt;
        push(8'h01);
        push(8'h80);
        wait_fetch("b2b_fetch");
        check_frame("b01", F_01);
        cyc();
        check_eq("b2b_gap_rd", 32'(bus.fifo_rd_en), 32'd1);
        check_frame("b80", F_80);
        cyc();
        check_eq("b2b_end_busy", 32'(bus.busy), 32'd0);
        check_eq("b2b_rd_pulses", 32'(rd_cnt - r0), 32'd2);

        // Write collides with FETCH: read voided, retried once wr_en drops.
        r0 = rd_cnt;
        push(8'h3C);
        cyc();
        check_eq("void_fetch_rd", 32'(bus.fifo_rd_en), 32'd1);
        bus.fifo_wr_en = 1'b1;
        cyc();
        check_eq("void_back_idle", 32'({bus.tx, bus.busy, bus.fifo_rd_en}), 32'b100);
        bus.fifo_wr_en = 1'b0;
        wait_fetch("void_retry_fetch");
        check_frame("v3c", F_3C);
        cyc();
        check_eq("void_end_busy", 32'(bus.busy), 32'd0);
        check_eq("void_rd_pulses", 32'(rd_cnt - r0), 32'd2);

        // Reset in the middle of data bit 0 of 0x00.
        push(8'h00);
        wait_fetch("rst_fetch");
        cyc();
        repeat (CPB + 2) cyc();
        check_eq("pre_rst_tx", 32'(bus.tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outputs", 32'({bus.tx, bus.busy, bus.fifo_rd_en}), 32'b100);
        cyc();
        rst_n = 1'b1;
        r0  = rd_cnt;
        bad = 0;
        repeat (20) begin
            cyc();
            if ((bus.tx !== 1'b1) || (bus.busy !== 1'b0)) bad++;
        end
        check_eq("post_rst_bad_cycles", 32'(bad), 32'd0);
        check_eq("post_rst_rd_pulses", 32'(rd_cnt - r0), 32'd0);
        push(8'h5A);
        wait_fetch("r5a_fetch");
        check_frame("r5a", F_5A);
        cyc();
        check_eq("r5a_end_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
